// File: rtl/branch_predict_unit.sv
// Branch resolution unit for the execute stage.
// Decodes eight branch types from the ALU flags and registers the taken
// decision and a misprediction pulse. It trains a pattern-history table of
// 2-bit saturating counters, which the fetch stage reads combinationally.
// It also keeps saturating counts of resolved branches and mispredictions.
module branch_predict_unit #(
  parameter int PC_W      = 32,
  parameter int PHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PC_W-1:0]  fetchPc_i,
  output logic             predTaken_o,
  input  logic             valid_i,
  input  logic [2:0]       branchType_i,
  input  logic             zf_i,
  input  logic             sign_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             predTaken_i,
  input  logic             statClear_i,
  output logic             resolveValid_o,
  output logic             branch_o,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branchCount_o,
  output logic [CNT_W-1:0] mispredictCount_o
);

  localparam int IDX_W = $clog2(PHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BGTZ = 3'b011,
    BR_BLEZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_JUMP = 3'b111
  } branchType_e;

  logic [1:0]       r_pht [PHT_DEPTH];
  logic             r_resolveValid;
  logic             r_branch;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_branchCount;
  logic [CNT_W-1:0] r_mispredictCount;

  logic             w_taken;
  logic             w_train;
  logic             w_mispredict;
  logic             w_isBranch;
  logic [IDX_W-1:0] w_resolveIdx;
  logic [IDX_W-1:0] w_fetchIdx;
  logic [1:0]       w_entry;
  logic             w_unusedPcBits;

  // PCs are word aligned, so the PHT index skips the two byte-offset bits.
  assign w_resolveIdx = pc_i[IDX_W+1:2];
  assign w_fetchIdx   = fetchPc_i[IDX_W+1:2];
  assign w_entry      = r_pht[w_resolveIdx];

  // The PHT index uses only part of each PC; the rest is folded here so the unused bits are explicit.
  assign w_unusedPcBits = ^{pc_i[PC_W-1:IDX_W+2], pc_i[1:0],
                            fetchPc_i[PC_W-1:IDX_W+2], fetchPc_i[1:0]};

  // Evaluate the branch condition for the resolving instruction from the ALU flags.
  always_comb begin
    w_taken = 1'b0;
    case (branchType_e'(branchType_i))
      BR_NONE: w_taken = 1'b0;
      BR_BEQ:  w_taken = zf_i;
      BR_BNE:  w_taken = ~zf_i;
      BR_BGTZ: w_taken = ~zf_i & ~sign_i;
      BR_BLEZ: w_taken = zf_i | sign_i;
      BR_BLTZ: w_taken = sign_i;
      BR_BGEZ: w_taken = ~sign_i;
      BR_JUMP: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // Only conditional branches train the PHT; "none" and unconditional jumps leave it untouched.
  assign w_isBranch   = valid_i && (branchType_i != BR_NONE);
  assign w_train      = w_isBranch && (branchType_i != BR_JUMP);
  assign w_mispredict = valid_i && (w_taken != predTaken_i);

  // Fetch reads the table with no bypass, so a same-cycle write is seen one cycle later.
  assign predTaken_o = r_pht[w_fetchIdx][1];

  // Train the addressed 2-bit counter, saturating at both ends; reset parks every entry at weakly not-taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (w_train) begin
      if (w_taken && (w_entry != 2'b11)) begin
        r_pht[w_resolveIdx] <= w_entry + 2'd1;
      end else if (!w_taken && (w_entry != 2'b00)) begin
        r_pht[w_resolveIdx] <= w_entry - 2'd1;
      end
    end
  end

  // Register the resolve result; all three flags are forced low on cycles without a request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_resolveValid <= 1'b0;
      r_branch       <= 1'b0;
      r_mispredict   <= 1'b0;
    end else begin
      r_resolveValid <= valid_i;
      r_branch       <= valid_i & w_taken;
      r_mispredict   <= w_mispredict;
    end
  end

  // Count resolved branches, saturating at all-ones; a clear wins over a simultaneous increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_branchCount <= '0;
    end else if (statClear_i) begin
      r_branchCount <= '0;
    end else if (w_isBranch && !(&r_branchCount)) begin
      r_branchCount <= r_branchCount + CNT_ONE;
    end
  end

  // Count mispredictions with the same saturate-and-clear behaviour.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mispredictCount <= '0;
    end else if (statClear_i) begin
      r_mispredictCount <= '0;
    end else if (w_mispredict && !(&r_mispredictCount)) begin
      r_mispredictCount <= r_mispredictCount + CNT_ONE;
    end
  end

  assign resolveValid_o    = r_resolveValid;
  assign branch_o          = r_branch;
  assign mispredict_o      = r_mispredict;
  assign branchCount_o     = r_branchCount;
  assign mispredictCount_o = r_mispredictCount;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: decode table, PHT training,
// no-bypass lookup, counter saturation/clear and reset dropping an in-flight branch.
// A second instance with 4-bit counters shares the inputs to reach saturation quickly.
module tb_branch_predict_unit;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] fetchPc_i;
  logic        valid_i;
  logic [2:0]  branchType_i;
  logic        zf_i;
  logic        sign_i;
  logic [31:0] pc_i;
  logic        predTaken_i;
  logic        statClear_i;

  logic        predTaken_o;
  logic        resolveValid_o;
  logic        branch_o;
  logic        mispredict_o;
  logic [15:0] branchCount_o;
  logic [15:0] mispredictCount_o;

  logic        smallPredTaken;
  logic        smallResolveValid;
  logic        smallBranch;
  logic        smallMispredict;
  logic [3:0]  smallBranchCount;
  logic [3:0]  smallMispredictCount;

  int vectorCount = 0;
  int missCount   = 0;
  int expMis;
  int expBr;

  branch_predict_unit #(.PC_W(32), .PHT_DEPTH(64), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetchPc_i(fetchPc_i), .predTaken_o(predTaken_o),
    .valid_i(valid_i), .branchType_i(branchType_i), .zf_i(zf_i), .sign_i(sign_i),
    .pc_i(pc_i), .predTaken_i(predTaken_i), .statClear_i(statClear_i),
    .resolveValid_o(resolveValid_o), .branch_o(branch_o), .mispredict_o(mispredict_o),
    .branchCount_o(branchCount_o), .mispredictCount_o(mispredictCount_o)
  );

  branch_predict_unit #(.PC_W(32), .PHT_DEPTH(64), .CNT_W(4)) dutSmall (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetchPc_i(fetchPc_i), .predTaken_o(smallPredTaken),
    .valid_i(valid_i), .branchType_i(branchType_i), .zf_i(zf_i), .sign_i(sign_i),
    .pc_i(pc_i), .predTaken_i(predTaken_i), .statClear_i(statClear_i),
    .resolveValid_o(smallResolveValid), .branch_o(smallBranch), .mispredict_o(smallMispredict),
    .branchCount_o(smallBranchCount), .mispredictCount_o(smallMispredictCount)
  );

  // Free-running clock, 10 time units per period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hand-written decode table: bit {zf,sign} of each row gives the taken value.
  function automatic logic expTaken(input logic [2:0] t, input logic z, input logic s);
    logic [3:0] row;
    case (t)
      3'd0: row = 4'b0000;
      3'd1: row = 4'b1100;
      3'd2: row = 4'b0011;
      3'd3: row = 4'b0001;
      3'd4: row = 4'b1110;
      3'd5: row = 4'b1010;
      3'd6: row = 4'b0101;
      default: row = 4'b1111;
    endcase
    return row[{z, s}];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic z, input logic s,
                               input logic [31:0] pc, input logic p);
    valid_i      = v;
    branchType_i = t;
    zf_i         = z;
    sign_i       = s;
    pc_i         = pc;
    predTaken_i  = p;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    statClear_i = 1'b0;
    fetchPc_i   = 32'h0;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;

    checkOutput("rst_resolveValid", {31'd0, resolveValid_o}, 32'd0);
    checkOutput("rst_branch", {31'd0, branch_o}, 32'd0);
    checkOutput("rst_mispredict", {31'd0, mispredict_o}, 32'd0);
    checkOutput("rst_branchCount", {16'd0, branchCount_o}, 32'd0);
    checkOutput("rst_mispredictCount", {16'd0, mispredictCount_o}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      fetchPc_i = i << 2;
      #1;
      checkOutput($sformatf("rst_pred_idx%0d", i), {31'd0, predTaken_o}, 32'd0);
    end

    // Decode sweep at pc 0x100 (index 0), predTaken_i=0 so mispredict equals taken.
    expMis = 0;
    for (int t = 0; t < 8; t++) begin
      for (int zs = 0; zs < 4; zs++) begin
        applyStimulus(1'b1, 3'(t), zs[1], zs[0], 32'h100, 1'b0);
        tick();
        checkOutput($sformatf("dec_branch_t%0d_zs%0d", t, zs), {31'd0, branch_o},
                    {31'd0, expTaken(3'(t), zs[1], zs[0])});
        checkOutput($sformatf("dec_mis_t%0d_zs%0d", t, zs), {31'd0, mispredict_o},
                    {31'd0, expTaken(3'(t), zs[1], zs[0])});
        checkOutput("dec_valid", {31'd0, resolveValid_o}, 32'd1);
        if (expTaken(3'(t), zs[1], zs[0])) expMis++;
      end
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("idle_valid", {31'd0, resolveValid_o}, 32'd0);
    checkOutput("idle_branch", {31'd0, branch_o}, 32'd0);
    checkOutput("sweep_branchCount", {16'd0, branchCount_o}, 32'd28);
    checkOutput("sweep_misCount_model", {16'd0, mispredictCount_o}, 32'(expMis));
    checkOutput("sweep_misCount_hand", {16'd0, mispredictCount_o}, 32'd16);
    checkOutput("sweep_small_branchCount", {28'd0, smallBranchCount}, 32'd15);
    checkOutput("sweep_small_misCount", {28'd0, smallMispredictCount}, 32'd15);

    // Type 000 with predTaken_i=1 is a mispredict but not a counted branch.
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 32'h100, 1'b1);
    tick();
    checkOutput("none_mis", {31'd0, mispredict_o}, 32'd1);
    checkOutput("none_branch", {31'd0, branch_o}, 32'd0);
    checkOutput("none_branchCount", {16'd0, branchCount_o}, 32'd28);
    checkOutput("none_misCount", {16'd0, mispredictCount_o}, 32'd17);

    // Train index 4 with three taken beq then two not-taken.
    fetchPc_i = 32'h10;
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 32'h10, 1'b0);
    #1;
    checkOutput("train_pred_before", {31'd0, predTaken_o}, 32'd0);
    tick();
    checkOutput("train_pred_t1", {31'd0, predTaken_o}, 32'd1);
    tick();
    checkOutput("train_pred_t2", {31'd0, predTaken_o}, 32'd1);
    tick();
    checkOutput("train_pred_t3", {31'd0, predTaken_o}, 32'd1);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'h10, 1'b1);
    tick();
    checkOutput("train_pred_n1", {31'd0, predTaken_o}, 32'd1);
    tick();
    checkOutput("train_pred_n2", {31'd0, predTaken_o}, 32'd0);

    // Same-cycle lookup returns the pre-update value; the update shows next cycle.
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 32'h10, 1'b0);
    #1;
    checkOutput("nobypass_same", {31'd0, predTaken_o}, 32'd0);
    tick();
    checkOutput("nobypass_next", {31'd0, predTaken_o}, 32'd1);

    // A jump at index 5 must not train: afterwards not-taken then taken returns 01 -> 00 -> 01.
    fetchPc_i = 32'h14;
    applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 32'h14, 1'b1);
    tick();
    checkOutput("jump_pred", {31'd0, predTaken_o}, 32'd0);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'h14, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 32'h14, 1'b0);
    tick();
    checkOutput("jump_no_write", {31'd0, predTaken_o}, 32'd0);

    // Saturation of the 4-bit instance: reset, then 16 jump mispredicts.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    expBr = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 32'h40, 1'b0);
      tick();
      expBr++;
      checkOutput($sformatf("sat_small_mis_%0d", k), {28'd0, smallMispredictCount},
                  (expBr > 15) ? 32'd15 : 32'(expBr));
    end
    checkOutput("sat_big_mis", {16'd0, mispredictCount_o}, 32'd16);
    checkOutput("sat_small_br", {28'd0, smallBranchCount}, 32'd15);
    statClear_i = 1'b1;
    tick();
    statClear_i = 1'b0;
    checkOutput("clr_small_mis", {28'd0, smallMispredictCount}, 32'd0);
    checkOutput("clr_big_mis", {16'd0, mispredictCount_o}, 32'd0);
    checkOutput("clr_big_br", {16'd0, branchCount_o}, 32'd0);
    checkOutput("clr_mis_pulse", {31'd0, mispredict_o}, 32'd1);

    // Reset together with a valid bne taken to index 7 drops the branch.
    fetchPc_i = 32'h1C;
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 32'h1C, 1'b0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rstfly_valid", {31'd0, resolveValid_o}, 32'd0);
    checkOutput("rstfly_branch", {31'd0, branch_o}, 32'd0);
    checkOutput("rstfly_mis", {31'd0, mispredict_o}, 32'd0);
    checkOutput("rstfly_brCount", {16'd0, branchCount_o}, 32'd0);
    checkOutput("rstfly_misCount", {16'd0, mispredictCount_o}, 32'd0);
    checkOutput("rstfly_pred", {31'd0, predTaken_o}, 32'd0);
    tick();
    checkOutput("rstfly_valid_after", {31'd0, resolveValid_o}, 32'd0);
    // Entry must be 01: one taken beq moves it to 10.
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 32'h1C, 1'b0);
    tick();
    checkOutput("rstfly_entry01", {31'd0, predTaken_o}, 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
